// File: rtl/im_loader.sv
// Boot-time instruction-memory loader: parses a length/data/checksum byte frame,
// writes big-endian 32-bit words to the memory and releases the CPU on success.
module im_loader #(
  parameter int IM_AW    = 13,
  parameter int IM_DEPTH = 8192
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [IM_AW-1:0] imaddr_d4,
  output logic [31:0]      imdin,
  output logic             imwe,
  output logic             imce,
  output logic             cpu_hold,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH17 = 17'(IM_DEPTH);

  state_t           state_q, state_d;
  logic [7:0]       lenhi_q, lenhi_d;
  logic [IM_AW:0]   nwords_q, nwords_d;
  logic [IM_AW:0]   wcnt_q, wcnt_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [23:0]      buf_q, buf_d;
  logic [7:0]       chk_q, chk_d;
  logic [IM_AW-1:0] imaddr_q, imaddr_d;
  logic [31:0]      imdin_q, imdin_d;
  logic             imwe_q, imwe_d;
  logic             rx_ready_q, rx_ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;

  logic             take;
  logic             clr;
  logic [15:0]      len16;

  assign take  = rx_valid && rx_ready_q;
  assign len16 = {lenhi_q, rx_data};

  always_comb begin
    state_d  = state_q;
    lenhi_d  = lenhi_q;
    nwords_d = nwords_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    buf_d    = buf_q;
    chk_d    = chk_q;
    imaddr_d = imaddr_q;
    imdin_d  = imdin_q;
    imwe_d   = 1'b0;
    clr      = 1'b0;

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          clr     = 1'b1;
          state_d = S_LEN0;
        end
      end
      S_LEN0: begin
        if (take) begin
          lenhi_d = rx_data;
          state_d = S_LEN1;
        end
      end
      S_LEN1: begin
        if (take) begin
          nwords_d = (IM_AW+1)'(len16);
          if ({1'b0, len16} > DEPTH17) state_d = S_ERR;
          else if (len16 == 16'd0)     state_d = S_CHK;
          else                         state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (take) begin
          chk_d  = chk_q ^ rx_data;
          bcnt_d = bcnt_q + 2'd1;
          buf_d  = {buf_q[15:0], rx_data};
          // Fourth byte bypasses the buffer straight into imdin, so the buffer
          // never stalls the stream.
          if (bcnt_q == 2'd3) begin
            imdin_d  = {buf_q, rx_data};
            imaddr_d = wcnt_q[IM_AW-1:0];
            imwe_d   = 1'b1;
            wcnt_d   = wcnt_q + (IM_AW+1)'(1);
            if (wcnt_d == nwords_q) state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (take) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end
      default: ;
    endcase

    if (clr) begin
      lenhi_d  = '0;
      nwords_d = '0;
      wcnt_d   = '0;
      bcnt_d   = '0;
      buf_d    = '0;
      chk_d    = '0;
    end

    rx_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                 (state_d == S_DATA) || (state_d == S_CHK);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERR);
    hold_d     = (state_d != S_DONE);
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= S_IDLE;
      lenhi_q    <= '0;
      nwords_q   <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      buf_q      <= '0;
      chk_q      <= '0;
      imaddr_q   <= '0;
      imdin_q    <= '0;
      imwe_q     <= 1'b0;
      rx_ready_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      lenhi_q    <= lenhi_d;
      nwords_q   <= nwords_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      buf_q      <= buf_d;
      chk_q      <= chk_d;
      imaddr_q   <= imaddr_d;
      imdin_q    <= imdin_d;
      imwe_q     <= imwe_d;
      rx_ready_q <= rx_ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hold_q     <= hold_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign imaddr_d4 = imaddr_q;
  assign imdin     = imdin_q;
  assign imwe      = imwe_q;
  assign imce      = imwe_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as bytes are driven
// and popped when the memory write port fires.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [12:0] imaddr;
  logic [31:0] imdin;
  logic        imwe, imce, cpu_hold, done, err;

  im_loader #(.IM_AW(13), .IM_DEPTH(8192)) dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imaddr_d4(imaddr), .imdin(imdin), .imwe(imwe), .imce(imce),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [12:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [31:0] words [0:3];
  int          errors = 0;
  int          checks = 0;
  int          wr_cnt = 0;
  logic        prev_we = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imce !== imwe) check("imce_eq_imwe", 32'(imce), 32'(imwe));
    if (imwe) begin
      wr_t e;
      wr_cnt++;
      if (prev_we) check("imwe_single", 32'(prev_we), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_wr", 32'(imaddr), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(imaddr), 32'(e.a));
        check("wr_data", imdin, e.d);
      end
    end
    prev_we <= imwe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    start = 1'b0;
    repeat (2) tick();
    sb.delete();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rx_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rx_timeout", 32'd0, 32'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int n, input bit bad, input bit gaps);
    logic [7:0] c = '0;
    logic [7:0] b;
    logic [15:0] n16 = 16'(n);
    send_byte(n16[15:8]);
    send_byte(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b = words[i][31-8*j -: 8];
        c ^= b;
        if (j == 3) sb.push_back({13'(i), words[i]});
        if (gaps && ($urandom_range(0, 2) == 0)) repeat ($urandom_range(1, 3)) tick();
        send_byte(b);
      end
    end
    send_byte(bad ? (c ^ 8'h01) : c);
    repeat (2) tick();
  endtask

  task automatic check_done(input string tag, input int base, input int nwr);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd0);
    check({tag, "_rdy"}, 32'(rx_ready), 32'd0);
    check({tag, "_nwr"}, 32'(wr_cnt - base), 32'(nwr));
    check({tag, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic check_err(input string tag, input int base, input int nwr);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_rdy"}, 32'(rx_ready), 32'd0);
    check({tag, "_nwr"}, 32'(wr_cnt - base), 32'(nwr));
  endtask

  initial begin
    int base;

    repeat (2) tick();
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdy", 32'(rx_ready), 32'd0);
    check("rst_we", 32'(imwe), 32'd0);
    do_reset();

    // Basic two-word image
    words[0] = 32'h3C09FEDC;
    words[1] = 32'h292A0001;
    base = wr_cnt;
    pulse_start();
    check("len0_rdy", 32'(rx_ready), 32'd1);
    send_frame(2, 1'b0, 1'b0);
    check_done("good2", base, 2);
    pulse_start();
    check("done_sticky", 32'(done), 32'd1);
    check("done_ign_start", 32'(rx_ready), 32'd0);

    // Bad checksum, then recovery from ERR via start
    do_reset();
    base = wr_cnt;
    pulse_start();
    send_frame(2, 1'b1, 1'b0);
    check_err("badchk", base, 2);
    base = wr_cnt;
    pulse_start();
    check("err_clr", 32'(err), 32'd0);
    send_frame(2, 1'b0, 1'b0);
    check_done("recover", base, 2);

    // Length above depth
    do_reset();
    base = wr_cnt;
    pulse_start();
    send_byte(8'h20);
    send_byte(8'h01);
    check_err("toolong", base, 0);
    repeat (3) tick();
    check("toolong_nwr", 32'(wr_cnt - base), 32'd0);

    // Zero-length image
    do_reset();
    base = wr_cnt;
    pulse_start();
    send_frame(0, 1'b0, 1'b0);
    check_done("len0_ok", base, 0);
    do_reset();
    base = wr_cnt;
    pulse_start();
    send_frame(0, 1'b1, 1'b0);
    check_err("len0_bad", base, 0);

    // Three words, back-to-back bytes mixed with random gaps
    do_reset();
    for (int i = 0; i < 3; i++) words[i] = $urandom();
    base = wr_cnt;
    pulse_start();
    send_frame(3, 1'b0, 1'b1);
    check_done("gaps3", base, 3);

    // Reset after five data bytes: one write only, outputs back to reset
    do_reset();
    words[0] = 32'hA1B2C3D4;
    words[1] = 32'h55667788;
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    for (int j = 0; j < 4; j++) begin
      if (j == 3) sb.push_back({13'd0, words[0]});
      send_byte(words[0][31-8*j -: 8]);
    end
    send_byte(words[1][31:24]);
    rst_n = 1'b0;
    #1;
    check("midrst_we", 32'(imwe), 32'd0);
    check("midrst_hold", 32'(cpu_hold), 32'd1);
    check("midrst_rdy", 32'(rx_ready), 32'd0);
    check("midrst_addr", 32'(imaddr), 32'd0);
    check("midrst_din", imdin, 32'd0);
    repeat (3) tick();
    check("midrst_nwr", 32'(wr_cnt - base), 32'd1);
    do_reset();
    base = wr_cnt;
    pulse_start();
    send_frame(2, 1'b0, 1'b0);
    check_done("after_rst", base, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
